// File: rtl/row_norm_serializer.sv
// row_norm_serializer: latches one output row plus its denominator and streams (O[i], l) pairs to the divider
module row_norm_serializer #(
    parameter int D     = 64,
    parameter int W     = 32,
    parameter int IDX_W = (D > 1) ? $clog2(D) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                vld_in,
    output logic                rdy_out,
    input  logic [D-1:0][W-1:0] row_in,
    input  logic [W-1:0]        denom_in,
    output logic                vld_out,
    input  logic                rdy_in,
    output logic [W-1:0]        numerator_out,
    output logic [W-1:0]        denominator_out,
    output logic                last_out,
    output logic                busy
);
    typedef enum logic {IDLE, STREAM} state_t;

    state_t               state;
    logic [IDX_W-1:0]     idx;
    logic [D-1:0][W-1:0]  row_reg;
    logic [W-1:0]         denom_reg;

    // Data outputs come straight from the held row, so no input ever reaches an output combinationally
    assign numerator_out   = row_reg[idx];
    assign denominator_out = denom_reg;

    // Row capture and element sequencing; handshake flags are registered alongside the state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            row_reg   <= '0;
            denom_reg <= '0;
            rdy_out   <= 1'b1;
            vld_out   <= 1'b0;
            busy      <= 1'b0;
            last_out  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (vld_in) begin
                        row_reg   <= row_in;
                        denom_reg <= denom_in;
                        idx       <= '0;
                        state     <= STREAM;
                        rdy_out   <= 1'b0;
                        vld_out   <= 1'b1;
                        busy      <= 1'b1;
                        last_out  <= (D == 1);
                    end
                end
                STREAM: begin
                    if (rdy_in) begin
                        if (idx == IDX_W'(D - 1)) begin
                            idx      <= '0;
                            state    <= IDLE;
                            rdy_out  <= 1'b1;
                            vld_out  <= 1'b0;
                            busy     <= 1'b0;
                            last_out <= 1'b0;
                        end else begin
                            idx      <= idx + IDX_W'(1);
                            last_out <= (idx + IDX_W'(1)) == IDX_W'(D - 1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_row_norm_serializer.sv
// tb_row_norm_serializer: directed vector table plus hand sequences for stall, reset and D=1 cases
module tb_row_norm_serializer;
    logic clk = 1'b0;
    logic rst = 1'b0;

    logic             vld_in = 1'b0, rdy_in = 1'b0;
    logic [3:0][15:0] row_in = '0;
    logic [15:0]      denom_in = '0;
    logic             rdy_out, vld_out, last_out, busy;
    logic [15:0]      num_out, den_out;

    logic             vld1 = 1'b0, rdy1_in = 1'b0;
    logic [0:0][15:0] row1 = '0;
    logic [15:0]      den1 = '0;
    logic             rdy1_out, vld1_out, last1_out, busy1;
    logic [15:0]      num1_out, den1_out;

    int n_cmp = 0;
    int n_bad = 0;

    row_norm_serializer #(.D(4), .W(16)) u4 (
        .clk(clk), .rst(rst), .vld_in(vld_in), .rdy_out(rdy_out), .row_in(row_in),
        .denom_in(denom_in), .vld_out(vld_out), .rdy_in(rdy_in), .numerator_out(num_out),
        .denominator_out(den_out), .last_out(last_out), .busy(busy)
    );

    row_norm_serializer #(.D(1), .W(16)) u1 (
        .clk(clk), .rst(rst), .vld_in(vld1), .rdy_out(rdy1_out), .row_in(row1),
        .denom_in(den1), .vld_out(vld1_out), .rdy_in(rdy1_in), .numerator_out(num1_out),
        .denominator_out(den1_out), .last_out(last1_out), .busy(busy1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             vld;
        logic             rdy;
        logic [3:0][15:0] row;
        logic [15:0]      den;
        logic             ev;
        logic [15:0]      en;
        logic [15:0]      ed;
        logic             el;
    } vec_t;

    vec_t tv[19];

    function automatic vec_t mk(logic vld, logic rdy, logic [3:0][15:0] row, logic [15:0] den,
                                logic ev, logic [15:0] en, logic [15:0] ed, logic el);
        vec_t v;
        v.vld = vld; v.rdy = rdy; v.row = row; v.den = den;
        v.ev = ev; v.en = en; v.ed = ed; v.el = el;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        logic [3:0][15:0] ra, rb, rc, rd;
        ra = {16'd40, 16'd30, 16'd20, 16'd10};
        rb = {16'd4, 16'd3, 16'd2, 16'd1};
        rc = {16'd8, 16'd8, 16'd8, 16'd8};
        rd = {16'd9, 16'd7, 16'd6, 16'd5};

        tv[0]  = mk(1, 1, ra, 5, 0, 0, 0, 0);
        tv[1]  = mk(0, 1, ra, 5, 1, 10, 5, 0);
        tv[2]  = mk(0, 0, ra, 5, 1, 20, 5, 0);
        tv[3]  = mk(0, 0, ra, 5, 1, 20, 5, 0);
        tv[4]  = mk(0, 0, ra, 5, 1, 20, 5, 0);
        tv[5]  = mk(0, 1, ra, 5, 1, 20, 5, 0);
        tv[6]  = mk(0, 1, ra, 5, 1, 30, 5, 0);
        tv[7]  = mk(0, 1, ra, 5, 1, 40, 5, 1);
        tv[8]  = mk(1, 1, rb, 1, 0, 0, 0, 0);
        tv[9]  = mk(1, 1, rc, 0, 1, 1, 1, 0);
        tv[10] = mk(1, 1, rc, 0, 1, 2, 1, 0);
        tv[11] = mk(1, 1, rc, 0, 1, 3, 1, 0);
        tv[12] = mk(1, 1, rc, 0, 1, 4, 1, 1);
        tv[13] = mk(1, 1, rc, 0, 0, 0, 0, 0);
        tv[14] = mk(0, 1, rc, 0, 1, 8, 0, 0);
        tv[15] = mk(0, 1, rc, 0, 1, 8, 0, 0);
        tv[16] = mk(0, 1, rc, 0, 1, 8, 0, 0);
        tv[17] = mk(0, 1, rc, 0, 1, 8, 0, 1);
        tv[18] = mk(0, 1, rc, 0, 0, 0, 0, 0);

        #3 rst = 1'b1;
        #1;
        chk("rst_vld", vld_out, 0);
        chk("rst_rdy", rdy_out, 1);
        chk("rst_busy", busy, 0);
        chk("rst_last", last_out, 0);
        chk("rst_num", num_out, 0);
        chk("rst_den", den_out, 0);
        chk("rst_vld_d1", vld1_out, 0);
        chk("rst_rdy_d1", rdy1_out, 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("idle_vld", vld_out, 0);
            chk("idle_rdy", rdy_out, 1);
        end

        for (int i = 0; i < 19; i++) begin
            vld_in = tv[i].vld; rdy_in = tv[i].rdy; row_in = tv[i].row; denom_in = tv[i].den;
            chk($sformatf("v%0d_vld", i), vld_out, tv[i].ev);
            chk($sformatf("v%0d_rdy", i), rdy_out, !tv[i].ev);
            chk($sformatf("v%0d_busy", i), busy, tv[i].ev);
            chk($sformatf("v%0d_last", i), last_out, tv[i].el);
            if (tv[i].ev) begin
                chk($sformatf("v%0d_num", i), num_out, tv[i].en);
                chk($sformatf("v%0d_den", i), den_out, tv[i].ed);
            end
            @(negedge clk);
        end

        vld_in = 1'b1; rdy_in = 1'b1; row_in = rb; denom_in = 16'd1;
        @(negedge clk);
        vld_in = 1'b0;
        chk("mid_p0", num_out, 1);
        @(negedge clk);
        chk("mid_p1", num_out, 2);
        @(negedge clk);
        chk("mid_p2_vld", vld_out, 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_vld", vld_out, 0);
        chk("mid_rst_rdy", rdy_out, 1);
        chk("mid_rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        vld_in = 1'b1; row_in = rd; denom_in = 16'd3;
        @(negedge clk);
        vld_in = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("new_vld%0d", k), vld_out, 1);
            chk($sformatf("new_num%0d", k), num_out, rd[k]);
            chk($sformatf("new_den%0d", k), den_out, 3);
            chk($sformatf("new_last%0d", k), last_out, k == 3);
            @(negedge clk);
        end
        chk("new_done_rdy", rdy_out, 1);
        chk("new_done_vld", vld_out, 0);

        vld1 = 1'b1; rdy1_in = 1'b1; row1 = 16'd100; den1 = 16'd7;
        @(negedge clk);
        vld1 = 1'b0;
        chk("d1_vld", vld1_out, 1);
        chk("d1_num", num1_out, 100);
        chk("d1_den", den1_out, 7);
        chk("d1_last", last1_out, 1);
        chk("d1_rdy_low", rdy1_out, 0);
        @(negedge clk);
        chk("d1_rdy", rdy1_out, 1);
        chk("d1_vld_off", vld1_out, 0);
        chk("d1_last_off", last1_out, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
